// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the memory-stage LSU (master) and data RAM / GEMM MMIO (slave).
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_we;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [3:0]        bus_req_be;
  logic [31:0]       bus_req_wdata;
  logic              bus_rsp_valid;
  logic [31:0]       bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_be, bus_req_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_be, bus_req_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: stalls the pipeline while one valid/ready bus access runs.
// Optional build macro MISALIGN_TRAP_EN traps misaligned half/word accesses without a bus cycle.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RSP_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              lsu_stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              bus_err,
  output logic              misalign_err,
  mem_stage_lsu_if.master   bus
);

  localparam int unsigned CNT_W = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        func3_q, func3_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;

  logic              access;
  logic              misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  // Reserved func3 codes never start an access, so they never stall.
  assign access = (mem_read | mem_write) & (func3 != 3'b011) &
                  (func3 != 3'b110) & (func3 != 3'b111);

`ifdef MISALIGN_TRAP_EN
  assign misaligned   = ((func3[1:0] == 2'b01) && addr[0]) ||
                        ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign misalign_err = (state_q == DONE) & mis_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata;
    case (func3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {addr[1], 1'b0};
        wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = bus.bus_rsp_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? bus.bus_rsp_rdata[31:16] : bus.bus_rsp_rdata[15:0];
    load_ext = bus.bus_rsp_rdata;
    case (func3_q[1:0])
      2'b00:   load_ext = {{24{byte_sel[7] & ~func3_q[2]}}, byte_sel};
      2'b01:   load_ext = {{16{half_sel[15] & ~func3_q[2]}}, half_sel};
      default: load_ext = bus.bus_rsp_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    func3_d   = func3_q;
    rdata_d   = rdata_q;
    cnt_d     = '0;
    err_d     = err_q;
    mis_d     = mis_q;
    lsu_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        lsu_stall = access;
        if (access) begin
          we_d    = mem_write;
          addr_d  = addr;
          be_d    = be_new;
          wdata_d = wdata_new;
          func3_d = func3;
          rdata_d = '0;
          err_d   = 1'b0;
          mis_d   = misaligned;
          state_d = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        lsu_stall = 1'b1;
        if (bus.bus_req_ready) begin
          state_d = RSP;
          cnt_d   = CNT_W'(1);
        end
      end
      RSP: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (bus.bus_rsp_valid) begin
          rdata_d = we_q ? '0 : load_ext;
          state_d = DONE;
        end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_W'(RSP_TIMEOUT))) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign rdata_valid = (state_q == DONE) & ~we_q & ~err_q & ~mis_q;
  assign rdata       = rdata_valid ? rdata_q : '0;
  assign bus_err     = (state_q == DONE) & err_q;

  assign bus.bus_req_valid = (state_q == REQ);
  assign bus.bus_req_we    = we_q;
  assign bus.bus_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.bus_req_be    = be_q;
  assign bus.bus_req_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed accesses push expected bus requests and
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_stage_lsu;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TMO    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        lsu_stall, rdata_valid, bus_err, misalign_err;
  logic [31:0] rdata;

  mem_stage_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stage_lsu #(.ADDR_W(ADDR_W), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
    .misalign_err(misalign_err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wd;
  } req_t;

  // kind is the expected {rdata_valid, bus_err, misalign_err} pattern
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int   passed = 0;
  int   total  = 0;

  localparam req_t NOREQ = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, chk_wd: 1'b0};
  localparam res_t NORES = '{kind: 3'b000, data: 32'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Bus slave: ready after rdy_dly waiting cycles, response rsp_dly cycles into RSP.
  int          rdy_dly = 0, rsp_dly = 0;
  bit          rsp_en = 1'b1;
  logic [31:0] rsp_word = '0;
  int          vcnt = 0, rcnt = 0;
  bit          pend = 1'b0;

  initial begin
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    if (bus.bus_req_valid) begin
      if (vcnt >= rdy_dly) begin
        bus.bus_req_ready = 1'b1;
        pend = 1'b1;
        rcnt = 0;
        vcnt = 0;
      end else vcnt++;
    end else begin
      vcnt = 0;
      if (pend) begin
        if (rsp_en && rcnt >= rsp_dly) begin
          bus.bus_rsp_valid = 1'b1;
          bus.bus_rsp_rdata = rsp_word;
          pend = 1'b0;
        end else rcnt++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    req_t e;
    res_t r;
    if (bus.bus_req_valid && bus.bus_req_ready) begin
      if (req_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_req: addr 0x%08h we %0b, none expected", bus.bus_req_addr, bus.bus_req_we);
      end else begin
        e = req_q.pop_front();
        check("req_we", {31'b0, bus.bus_req_we}, {31'b0, e.we});
        check("req_addr", bus.bus_req_addr, e.addr);
        check("req_be", {28'b0, bus.bus_req_be}, {28'b0, e.be});
        if (e.chk_wd) check("req_wdata", bus.bus_req_wdata, e.wdata);
      end
    end
    if (rdata_valid || bus_err || misalign_err) begin
      if (res_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: valid/err/mis %0b%0b%0b rdata 0x%08h, none expected",
                 rdata_valid, bus_err, misalign_err, rdata);
      end else begin
        r = res_q.pop_front();
        check("res_kind", {29'b0, rdata_valid, bus_err, misalign_err}, {29'b0, r.kind});
        check("res_rdata", rdata, r.data);
      end
    end
  end

  task automatic access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int rdly, input int sdly,
                        input bit ren, input logic [31:0] rword, input bit has_req, input req_t er,
                        input bit has_res, input res_t eres, input int exp_stall);
    int stalls = 0;
    int unstable = 0;
    int cyc = 0;
    bit done = 1'b0;
    rdy_dly = rdly; rsp_dly = sdly; rsp_en = ren; rsp_word = rword;
    if (has_req) req_q.push_back(er);
    if (has_res) res_q.push_back(eres);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (lsu_stall) stalls++;
      else done = 1'b1;
      if (bus.bus_req_valid && (bus.bus_req_addr !== er.addr || bus.bus_req_be !== er.be ||
          bus.bus_req_we !== er.we || (er.chk_wd && bus.bus_req_wdata !== er.wdata)))
        unstable++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    if (has_req) check({name, "_req_stable"}, 32'(unstable), 32'd0);
    repeat (2) @(negedge clk);
    check({name, "_drain"}, 32'(req_q.size() + res_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    int pulses;
    int busy;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {26'b0, lsu_stall, rdata_valid, bus_err, misalign_err, bus.bus_req_valid, bus.bus_req_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_req_addr", bus.bus_req_addr, 32'd0);
    check("rst_req_be_wdata", {28'b0, bus.bus_req_be} | bus.bus_req_wdata, 32'd0);

    access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 1, 32'hDEADBEEF,
           1, '{1'b0, 32'h100, 4'hF, 32'h0, 1'b0}, 1, '{3'b100, 32'hDEADBEEF}, 3);
    access("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 1, 32'h0,
           1, '{1'b1, 32'h100, 4'h8, 32'hA5A5A5A5, 1'b1}, 0, NORES, 3);
    access("lb", 1, 0, 3'b000, 32'h102, 32'h0, 0, 0, 1, 32'h00800000,
           1, '{1'b0, 32'h100, 4'h4, 32'h0, 1'b0}, 1, '{3'b100, 32'hFFFFFF80}, 3);
    access("lbu", 1, 0, 3'b100, 32'h102, 32'h0, 0, 0, 1, 32'h00800000,
           1, '{1'b0, 32'h100, 4'h4, 32'h0, 1'b0}, 1, '{3'b100, 32'h00000080}, 3);
    access("lb_pos", 1, 0, 3'b000, 32'h101, 32'h0, 0, 0, 1, 32'h00007F00,
           1, '{1'b0, 32'h100, 4'h2, 32'h0, 1'b0}, 1, '{3'b100, 32'h0000007F}, 3);
    access("lh", 1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 1, 32'hBEEF1234,
           1, '{1'b0, 32'h100, 4'hC, 32'h0, 1'b0}, 1, '{3'b100, 32'hFFFFBEEF}, 3);
    access("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 0, 0, 1, 32'hBEEF1234,
           1, '{1'b0, 32'h100, 4'h3, 32'h0, 1'b0}, 1, '{3'b100, 32'h00001234}, 3);
    access("sh", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 1, 32'h0,
           1, '{1'b1, 32'h100, 4'hC, 32'hABCDABCD, 1'b1}, 0, NORES, 3);
    access("sw", 0, 1, 3'b010, 32'h104, 32'h11223344, 0, 0, 1, 32'h0,
           1, '{1'b1, 32'h104, 4'hF, 32'h11223344, 1'b1}, 0, NORES, 3);
    access("rd_wr_both", 1, 1, 3'b010, 32'h108, 32'hCAFEBABE, 0, 0, 1, 32'h55555555,
           1, '{1'b1, 32'h108, 4'hF, 32'hCAFEBABE, 1'b1}, 0, NORES, 3);
    access("f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 1, 32'h0, 0, NOREQ, 0, NORES, 0);
    access("f3_111", 0, 1, 3'b111, 32'h100, 32'h0, 0, 0, 1, 32'h0, 0, NOREQ, 0, NORES, 0);
    access("lw_slow", 1, 0, 3'b010, 32'h200, 32'h0, 5, 3, 1, 32'h12345678,
           1, '{1'b0, 32'h200, 4'hF, 32'h0, 1'b0}, 1, '{3'b100, 32'h12345678}, 11);
    access("lw_timeout", 1, 0, 3'b010, 32'h300, 32'h0, 0, 0, 0, 32'h0,
           1, '{1'b0, 32'h300, 4'hF, 32'h0, 1'b0}, 1, '{3'b010, 32'h0}, 6);
    pend = 1'b0;
    access("lw_after_tmo", 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 1, 32'h0BADF00D,
           1, '{1'b0, 32'h100, 4'hF, 32'h0, 1'b0}, 1, '{3'b100, 32'h0BADF00D}, 3);

    // Reset lands in RSP; the response arrives the cycle after and must be discarded.
    rdy_dly = 0; rsp_dly = 1; rsp_en = 1'b1; rsp_word = 32'hCAFEF00D;
    req_q.push_back('{1'b0, 32'h400, 4'hF, 32'h0, 1'b0});
    @(posedge clk); #1;
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h400;
    cyc = 0;
    while (!(bus.bus_req_valid && bus.bus_req_ready) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_handshake_seen", {31'b0, bus.bus_req_valid & bus.bus_req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0; busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdata_valid || bus_err || misalign_err) pulses++;
      if (lsu_stall || bus.bus_req_valid) busy++;
    end
    check("rst_mid_no_result", 32'(pulses), 32'd0);
    check("rst_mid_idle", 32'(busy), 32'd0);
    check("rst_mid_drain", 32'(req_q.size() + res_q.size()), 32'd0);
    rsp_dly = 0;
    access("lbu_after_rst", 1, 0, 3'b100, 32'h503, 32'h0, 0, 0, 1, 32'hF1000000,
           1, '{1'b0, 32'h500, 4'h8, 32'h0, 1'b0}, 1, '{3'b100, 32'h000000F1}, 3);

`ifdef MISALIGN_TRAP_EN
    access("lw_misalign", 1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 1, 32'h01020304,
           0, NOREQ, 1, '{3'b001, 32'h0}, 1);
    access("sh_misalign", 0, 1, 3'b001, 32'h101, 32'h0000BEEF, 0, 0, 1, 32'h0,
           0, NOREQ, 1, '{3'b001, 32'h0}, 1);
`else
    access("lw_unaligned", 1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 1, 32'h01020304,
           1, '{1'b0, 32'h100, 4'hF, 32'h0, 1'b0}, 1, '{3'b100, 32'h01020304}, 3);
    access("lh_odd", 1, 0, 3'b001, 32'h103, 32'h0, 0, 0, 1, 32'h8001ABCD,
           1, '{1'b0, 32'h100, 4'hC, 32'h0, 1'b0}, 1, '{3'b100, 32'hFFFF8001}, 3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
